// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined ALU: opcodes, operand-B select, FSM states.
package alu_pipe_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_MUL  = 4'd2,  OP_SHR  = 4'd3,
      OP_SHL  = 4'd4,  OP_ROR  = 4'd5,  OP_ROL  = 4'd6,  OP_NOT  = 4'd7,
      OP_AND  = 4'd8,  OP_OR   = 4'd9,  OP_XOR  = 4'd10, OP_NAND = 4'd11,
      OP_NOR  = 4'd12, OP_XNOR = 4'd13, OP_INC  = 4'd14, OP_DEC  = 4'd15
   } op_e;

   typedef enum logic [1:0] {
      MOVI_REGB = 2'd0,
      MOVI_MEM  = 2'd1,
      MOVI_IMM  = 2'd2,
      MOVI_ZERO = 2'd3
   } movi_e;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   localparam int unsigned RES_MULT = 2;

   // Result bus is wide enough to hold a full unsigned product.
   function automatic int unsigned res_width(input int unsigned w);
      return RES_MULT * w;
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, W steps.
module alu_mul_iter
   import alu_pipe_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                                i_clk,
   input  logic                                i_rst,
   input  logic                                i_start,
   input  logic [DATA_WIDTH-1:0]               i_a,
   input  logic [DATA_WIDTH-1:0]               i_b,
   output logic                                o_done_c,
   output logic [res_width(DATA_WIDTH)-1:0]    o_prod_c
);

   localparam int unsigned W  = DATA_WIDTH;
   localparam int unsigned RW = res_width(W);
   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

   logic          r_busy;
   logic [CW-1:0] r_cnt;
   logic [RW-1:0] r_acc;
   logic [RW-1:0] r_mcand;
   logic [W-1:0]  r_mplier;
   logic [RW-1:0] w_addend;
   logic [RW-1:0] w_acc_next;

   assign w_addend   = r_mplier[0] ? r_mcand : '0;
   assign w_acc_next = r_acc + w_addend;

   // Final step's sum is presented directly so the top can capture it on the same edge.
   assign o_done_c = r_busy && (r_cnt == CW'(W - 1));
   assign o_prod_c = w_acc_next;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
      end else if (i_start) begin
         r_busy   <= 1'b1;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= RW'(i_a);
         r_mplier <= i_b;
      end else if (r_busy) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CW'(1);
         if (o_done_c) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_pipe_mul.sv
// Parametrised ALU with one-cycle registered results and an optional
// iterative multiplier that stalls new requests while it runs.
module alu_pipe_mul
   import alu_pipe_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MUL_ITER   = 1
) (
   input  logic                              CLK,
   input  logic                              RST,
   input  logic                              ACT,
   input  logic [3:0]                        OP,
   input  logic [1:0]                        MOVI,
   input  logic [DATA_WIDTH-1:0]             REGA,
   input  logic [DATA_WIDTH-1:0]             REGB,
   input  logic [DATA_WIDTH-1:0]             MEM,
   input  logic [DATA_WIDTH-1:0]             IMM,
   output logic [res_width(DATA_WIDTH)-1:0]  EX_ALU,
   output logic                              EX_ALU_VLD,
   output logic                              ALU_RDY
);

   localparam int unsigned W    = DATA_WIDTH;
   localparam int unsigned W1   = W + 1;
   localparam int unsigned RW   = res_width(W);
   localparam bit          ITER = (MUL_ITER != 0);

   state_e        r_state;
   logic [RW-1:0] r_ex;
   logic          r_vld;
   logic          r_rdy;

   op_e           w_op;
   logic [W-1:0]  w_b;
   logic [W:0]    w_sum;
   logic [W:0]    w_diff;
   logic [W:0]    w_inc;
   logic [W:0]    w_dec;
   logic [RW-1:0] w_mul;
   logic [W-1:0]  w_narrow;
   logic [RW-1:0] w_res;
   logic          w_start;
   logic          w_done_c;
   logic [RW-1:0] w_prod;

   assign w_op = op_e'(OP);

   always_comb begin
      w_b = '0;
      case (movi_e'(MOVI))
         MOVI_REGB: w_b = REGB;
         MOVI_MEM:  w_b = MEM;
         MOVI_IMM:  w_b = IMM;
         default:   w_b = '0;
      endcase
   end

   // Arithmetic kept at W+1 bits so the carry/borrow lands in bit W and nothing above.
   assign w_sum  = {1'b0, REGA} + {1'b0, w_b};
   assign w_diff = {1'b0, REGA} - {1'b0, w_b};
   assign w_inc  = {1'b0, REGA} + W1'(1);
   assign w_dec  = {1'b0, REGA} - W1'(1);
   assign w_mul  = ITER ? '0 : (RW'(REGA) * RW'(w_b));

   always_comb begin
      w_narrow = '0;
      case (w_op)
         OP_SHR:  w_narrow = REGA >> 1;
         OP_SHL:  w_narrow = REGA << 1;
         OP_ROR:  w_narrow = {REGA[0], REGA[W-1:1]};
         OP_ROL:  w_narrow = {REGA[W-2:0], REGA[W-1]};
         OP_NOT:  w_narrow = ~REGA;
         OP_AND:  w_narrow = REGA & w_b;
         OP_OR:   w_narrow = REGA | w_b;
         OP_XOR:  w_narrow = REGA ^ w_b;
         OP_NAND: w_narrow = ~(REGA & w_b);
         OP_NOR:  w_narrow = ~(REGA | w_b);
         OP_XNOR: w_narrow = ~(REGA ^ w_b);
         default: w_narrow = '0;
      endcase
   end

   always_comb begin
      w_res = RW'(w_narrow);
      case (w_op)
         OP_ADD:  w_res = RW'(w_sum);
         OP_SUB:  w_res = RW'(w_diff);
         OP_INC:  w_res = RW'(w_inc);
         OP_DEC:  w_res = RW'(w_dec);
         OP_MUL:  w_res = w_mul;
         default: w_res = RW'(w_narrow);
      endcase
   end

   assign w_start = ITER && ACT && r_rdy && (r_state == IDLE) && (w_op == OP_MUL);

   generate
      if (ITER) begin : g_iter
         alu_mul_iter #(
            .DATA_WIDTH (W)
         ) u_mul (
            .i_clk    (CLK),
            .i_rst    (RST),
            .i_start  (w_start),
            .i_a      (REGA),
            .i_b      (w_b),
            .o_done_c (w_done_c),
            .o_prod_c (w_prod)
         );
      end else begin : g_comb
         assign w_done_c = 1'b0;
         assign w_prod   = '0;
      end
   endgenerate

   // Control FSM and output registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
         r_ex    <= '0;
         r_vld   <= 1'b0;
         r_rdy   <= 1'b0;
      end else begin
         r_vld <= 1'b0;
         case (r_state)
            IDLE: begin
               r_rdy <= 1'b1;
               if (ACT && r_rdy) begin
                  if (w_start) begin
                     r_state <= BUSY;
                     r_rdy   <= 1'b0;
                  end else begin
                     r_ex  <= w_res;
                     r_vld <= 1'b1;
                  end
               end
            end
            BUSY: begin
               if (w_done_c) begin
                  r_state <= IDLE;
                  r_ex    <= w_prod;
                  r_vld   <= 1'b1;
                  r_rdy   <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign EX_ALU     = r_ex;
   assign EX_ALU_VLD = r_vld;
   assign ALU_RDY    = r_rdy;

endmodule

// File: tb/tb_alu_pipe_mul.sv
// Self-checking bench: iterative (MUL_ITER=1) and single-cycle (MUL_ITER=0) instances side by side.
module tb_alu_pipe_mul;

   localparam int W = 8;

   logic        CLK;
   logic        rst, act;
   logic [3:0]  op;
   logic [1:0]  movi;
   logic [7:0]  rega, regb, mem, imm;
   logic [15:0] ex_it, ex_cb;
   logic        vld_it, vld_cb, rdy_it, rdy_cb;

   int n_pass  = 0;
   int n_total = 0;
   int last_ex = 0;

   alu_pipe_mul #(.DATA_WIDTH(8), .MUL_ITER(1)) dut_it (
      .CLK(CLK), .RST(rst), .ACT(act), .OP(op), .MOVI(movi),
      .REGA(rega), .REGB(regb), .MEM(mem), .IMM(imm),
      .EX_ALU(ex_it), .EX_ALU_VLD(vld_it), .ALU_RDY(rdy_it));

   alu_pipe_mul #(.DATA_WIDTH(8), .MUL_ITER(0)) dut_cb (
      .CLK(CLK), .RST(rst), .ACT(act), .OP(op), .MOVI(movi),
      .REGA(rega), .REGB(regb), .MEM(mem), .IMM(imm),
      .EX_ALU(ex_cb), .EX_ALU_VLD(vld_cb), .ALU_RDY(rdy_cb));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      int op;
      int movi;
      int a;
      int rb;
      int mem;
      int imm;
      int exp;
   } vec_t;

   vec_t vecs [17];

   // Reference: plain integer arithmetic on 8-bit operands.
   function automatic int model(input int o, input int a, input int b);
      case (o)
         0:  return (a + b) % 512;
         1:  return (a - b + 512) % 512;
         2:  return a * b;
         3:  return a / 2;
         4:  return (a * 2) % 256;
         5:  return a / 2 + (a % 2) * 128;
         6:  return (a * 2) % 256 + a / 128;
         7:  return 255 - a;
         8:  return a & b;
         9:  return a | b;
         10: return a ^ b;
         11: return 255 - (a & b);
         12: return 255 - (a | b);
         13: return 255 - (a ^ b);
         14: return (a + 1) % 512;
         15: return (a + 511) % 512;
         default: return 0;
      endcase
   endfunction

   function automatic int pick_b(input int m, input int rb, input int me, input int im);
      case (m)
         0: return rb;
         1: return me;
         2: return im;
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string name, input int actual, input int expected);
      n_total++;
      if (actual == expected) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input int o, input int m, input int a, input int rb,
                        input int me, input int im, input int ac);
      op   = 4'(o);
      movi = 2'(m);
      rega = 8'(a);
      regb = 8'(rb);
      mem  = 8'(me);
      imm  = 8'(im);
      act  = 1'(ac);
   endtask

   // MUL on both instances; ADDs issued during the iterative run go only to the single-cycle one.
   task automatic mul_seq(input int m, input int a, input int bval, input int exp, input string tag);
      int rb, me, im, ra, rbb;
      rb = (m == 0) ? bval : int'($urandom_range(0, 255));
      me = (m == 1) ? bval : int'($urandom_range(0, 255));
      im = (m == 2) ? bval : int'($urandom_range(0, 255));
      drive(2, m, a, rb, me, im, 1);
      tick();
      chk({tag, "_cb_ex"},  ex_cb,  exp);
      chk({tag, "_cb_vld"}, vld_cb, 1);
      chk({tag, "_cb_rdy"}, rdy_cb, 1);
      chk({tag, "_it_rdy0"}, rdy_it, 0);
      chk({tag, "_it_vld0"}, vld_it, 0);
      for (int c = 1; c <= W; c++) begin
         ra  = int'($urandom_range(0, 255));
         rbb = int'($urandom_range(0, 255));
         drive(0, 0, ra, rbb, $urandom_range(0, 255), $urandom_range(0, 255), 1);
         tick();
         chk($sformatf("%s_cb_add%0d", tag, c), ex_cb, model(0, ra, rbb));
         chk($sformatf("%s_cb_vld%0d", tag, c), vld_cb, 1);
         if (c < W) begin
            chk($sformatf("%s_it_busy_vld%0d", tag, c), vld_it, 0);
            chk($sformatf("%s_it_busy_rdy%0d", tag, c), rdy_it, 0);
         end else begin
            chk({tag, "_it_ex"},  ex_it,  exp);
            chk({tag, "_it_vld"}, vld_it, 1);
            chk({tag, "_it_rdy"}, rdy_it, 1);
         end
      end
      drive(0, 0, 2, 3, 0, 0, 1);
      tick();
      chk({tag, "_it_next_ex"},  ex_it,  5);
      chk({tag, "_it_next_vld"}, vld_it, 1);
      chk({tag, "_cb_next_ex"},  ex_cb,  5);
      act = 1'b0;
      tick();
      chk({tag, "_it_idle_vld"}, vld_it, 0);
      chk({tag, "_cb_idle_vld"}, vld_cb, 0);
      chk({tag, "_it_hold_ex"},  ex_it,  5);
   endtask

   initial begin
      vecs[0]  = '{0,  0, 'hFF, 'h01, 'h00, 'h00, 'h0100};
      vecs[1]  = '{1,  2, 'h00, 'h55, 'h66, 'h01, 'h01FF};
      vecs[2]  = '{0,  3, 'h05, 'h77, 'h12, 'h34, 'h0005};
      vecs[3]  = '{10, 0, 'hF0, 'h3C, 'h00, 'h00, 'h00CC};
      vecs[4]  = '{6,  3, 'h81, 'h11, 'h22, 'h33, 'h0003};
      vecs[5]  = '{15, 1, 'h00, 'h44, 'h55, 'h66, 'h01FF};
      vecs[6]  = '{3,  0, 'h81, 'hFF, 'hFF, 'hFF, 'h0040};
      vecs[7]  = '{4,  2, 'h81, 'hFF, 'hFF, 'hFF, 'h0002};
      vecs[8]  = '{5,  1, 'h81, 'hFF, 'hFF, 'hFF, 'h00C0};
      vecs[9]  = '{7,  1, 'h5A, 'h00, 'hFF, 'h00, 'h00A5};
      vecs[10] = '{8,  1, 'h5A, 'hFF, 'h0F, 'h00, 'h000A};
      vecs[11] = '{9,  1, 'h5A, 'h00, 'h0F, 'hFF, 'h005F};
      vecs[12] = '{11, 0, 'hF0, 'h3C, 'h00, 'h00, 'h00CF};
      vecs[13] = '{12, 0, 'hF0, 'h3C, 'h00, 'h00, 'h0003};
      vecs[14] = '{13, 0, 'hF0, 'h3C, 'h00, 'h00, 'h0033};
      vecs[15] = '{14, 0, 'hFF, 'h00, 'h00, 'h00, 'h0100};
      vecs[16] = '{1,  0, 'h10, 'h20, 'h00, 'h00, 'h01F0};

      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      chk("rst_ex_it",  ex_it,  0);
      chk("rst_vld_it", vld_it, 0);
      chk("rst_rdy_it", rdy_it, 0);
      chk("rst_ex_cb",  ex_cb,  0);
      chk("rst_rdy_cb", rdy_cb, 0);
      rst = 1'b0;
      tick();
      chk("post_rst_rdy_it", rdy_it, 1);
      chk("post_rst_rdy_cb", rdy_cb, 1);

      // Back-to-back directed vectors, one per cycle.
      foreach (vecs[i]) begin
         drive(vecs[i].op, vecs[i].movi, vecs[i].a, vecs[i].rb, vecs[i].mem, vecs[i].imm, 1);
         tick();
         chk($sformatf("tbl%0d_it_ex", i),  ex_it,  vecs[i].exp);
         chk($sformatf("tbl%0d_it_vld", i), vld_it, 1);
         chk($sformatf("tbl%0d_it_rdy", i), rdy_it, 1);
         chk($sformatf("tbl%0d_cb_ex", i),  ex_cb,  vecs[i].exp);
         chk($sformatf("tbl%0d_cb_vld", i), vld_cb, 1);
      end
      act = 1'b0;
      tick();
      chk("tbl_idle_vld", vld_it, 0);
      chk("tbl_hold_ex",  ex_it,  'h01F0);

      mul_seq(1, 'hFF, 'hFF, 'hFE01, "mul_ff");
      mul_seq(0, 'h0C, 'h0A, 'h0078, "mul_0c");
      for (int k = 0; k < 4; k++) begin
         int a, b, m;
         a = int'($urandom_range(0, 255));
         b = int'($urandom_range(0, 255));
         m = int'($urandom_range(0, 3));
         mul_seq(m, a, b, model(2, a, pick_b(m, b, b, b)), $sformatf("mul_rnd%0d", k));
      end

      // Reset during the fourth multiply step discards the operation.
      drive(2, 0, 'h37, 'h5B, 0, 0, 1);
      tick();
      act = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         tick();
         chk($sformatf("abort_pre_vld%0d", c), vld_it, 0);
      end
      rst = 1'b1;
      tick();
      chk("abort_ex_it",  ex_it,  0);
      chk("abort_vld_it", vld_it, 0);
      chk("abort_rdy_it", rdy_it, 0);
      chk("abort_ex_cb",  ex_cb,  0);
      rst = 1'b0;
      for (int c = 1; c <= W + 2; c++) begin
         tick();
         chk($sformatf("abort_post_vld%0d", c), vld_it, 0);
         if (c == 1) begin
            chk("abort_rdy_it_back", rdy_it, 1);
            chk("abort_rdy_cb_back", rdy_cb, 1);
         end
      end
      drive(0, 0, 2, 3, 0, 0, 1);
      tick();
      chk("abort_add_ex",  ex_it,  5);
      chk("abort_add_vld", vld_it, 1);
      last_ex = 5;

      // Random non-MUL traffic with random gaps.
      for (int n = 0; n < 300; n++) begin
         int o, m, a, rb, me, im, ac, e;
         o  = int'($urandom_range(0, 15));
         if (o == 2) o = 10;
         m  = int'($urandom_range(0, 3));
         a  = int'($urandom_range(0, 255));
         rb = int'($urandom_range(0, 255));
         me = int'($urandom_range(0, 255));
         im = int'($urandom_range(0, 255));
         ac = ($urandom_range(0, 3) != 0) ? 1 : 0;
         e  = model(o, a, pick_b(m, rb, me, im));
         drive(o, m, a, rb, me, im, ac);
         tick();
         if (ac == 1) last_ex = e;
         chk($sformatf("rnd%0d_op%0d_it_ex", n, o), ex_it,  last_ex);
         chk($sformatf("rnd%0d_op%0d_cb_ex", n, o), ex_cb,  last_ex);
         chk($sformatf("rnd%0d_it_vld", n),         vld_it, ac);
         chk($sformatf("rnd%0d_it_rdy", n),         rdy_it, 1);
      end
      act = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
